ram_2ports_be_clr: RTL and testbench

//  Parametrised simple-dual-port RAM (one write port, one read port), successor to the plain 2-port RAM.

---
 rtl/ram_pkg.sv | 36 +++
 rtl/ram_2ports_be_clr_if.sv | 33 +++
 rtl/ram_clr_ctrl.sv | 69 ++++++
 rtl/ram_2ports_be_clr.sv | 97 +++++++++
 tb/tb_ram_2ports_be_clr.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for ram_2ports_be_clr: clear-FSM state, byte-lane count
// and the byte-enable lane merge used by both the write path and the read bypass.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Upper bounds for the width-generic merge helper; callers zero-extend into these.
  localparam int MAX_DW = 1024;
  localparam int MAX_NB = 1024;

  function automatic int nbytes(input int dw, input int bw);
    return dw / bw;
  endfunction

  function automatic logic [MAX_DW-1:0] merge_be(input logic [MAX_DW-1:0] old_w,
                                                 input logic [MAX_DW-1:0] new_w,
                                                 input logic [MAX_NB-1:0] be,
                                                 input int                bw);
    logic [MAX_DW-1:0] res;
    int lane;
    res = old_w;
    for (int j = 0; j < MAX_DW; j++) begin
      lane = j / bw;
      if (be[lane[9:0]]) begin
        res[j[9:0]] = new_w[j[9:0]];
      end else begin
        res[j[9:0]] = old_w[j[9:0]];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_2ports_be_clr_if.sv
// Port bundle for ram_2ports_be_clr: write port, read port and clear request/busy.
interface ram_2ports_be_clr_if
  import ram_pkg::*;
#(
  parameter int addr_width = 4,
  parameter int data_width = 16,
  parameter int byte_width = 8
);

  localparam int NBYTES = nbytes(data_width, byte_width);

  logic                  clr_req;
  logic                  busy;
  logic                  we;
  logic [addr_width-1:0] w_addr;
  logic [data_width-1:0] w_data;
  logic [NBYTES-1:0]     w_be;
  logic                  re;
  logic [addr_width-1:0] r_addr;
  logic [data_width-1:0] r_data;
  logic                  r_valid;

  modport master (
    output clr_req, we, w_addr, w_data, w_be, re, r_addr,
    input  busy, r_data, r_valid
  );

  modport slave (
    input  clr_req, we, w_addr, w_data, w_be, re, r_addr,
    output busy, r_data, r_valid
  );

endinterface

// File: rtl/ram_clr_ctrl.sv
// Clear-sweep controller: walks every address once after reset or on clr_req,
// flagging busy while the sweep owns the write port.
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [addr_width-1:0] clr_addr_o
);

  localparam logic [addr_width-1:0] LAST_ADDR = {addr_width{1'b1}};

  clr_state_e            state_q, state_d;
  logic [addr_width-1:0] clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;

  // Next-state logic; the counter wraps to zero on the last sweep address.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + addr_width'(1'b1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = READY;
        end else begin
          state_d = CLEAR;
        end
      end
      READY: begin
        if (clr_req_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else begin
          state_d   = READY;
          clr_cnt_d = clr_cnt_q;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // State, sweep counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = clr_cnt_q;

endmodule

// File: rtl/ram_2ports_be_clr.sv
// Simple-dual-port RAM with byte enables, registered read + valid, and clear sweep.
// Define RAM_BYPASS_EN for write-first data on a same-address read/write collision.
module ram_2ports_be_clr
  import ram_pkg::*;
#(
  parameter int                    addr_width = 4,
  parameter int                    data_width = 16,
  parameter int                    byte_width = 8,
  parameter logic [byte_width-1:0] clr_value  = {byte_width{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_2ports_be_clr_if.slave bus
);

  localparam int NBYTES = nbytes(data_width, byte_width);
  localparam int DEPTH  = 2 ** addr_width;
  localparam logic [data_width-1:0] CLR_WORD = {NBYTES{clr_value}};

  if ((data_width % byte_width) != 0) begin : g_bad_lane_width
    $fatal(1, "ram_2ports_be_clr: data_width must be a multiple of byte_width");
  end
  if (data_width > MAX_DW) begin : g_bad_data_width
    $fatal(1, "ram_2ports_be_clr: data_width exceeds ram_pkg::MAX_DW");
  end

  logic [data_width-1:0] mem_q [DEPTH];
  logic [data_width-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;

  logic                  busy_s;
  logic                  clr_we_s;
  logic [addr_width-1:0] clr_addr_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [data_width-1:0] wr_word_s;
  logic [data_width-1:0] rd_word_s;

  ram_clr_ctrl #(
    .addr_width (addr_width)
  ) u_clr_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (bus.clr_req),
    .busy_o     (busy_s),
    .clr_we_o   (clr_we_s),
    .clr_addr_o (clr_addr_s)
  );

  // A clear request in the same cycle drops the write but lets the read complete.
  always_comb begin
    wr_en_s   = !busy_s && bus.we && !bus.clr_req;
    rd_en_s   = !busy_s && bus.re;
    wr_word_s = data_width'(merge_be(MAX_DW'(mem_q[bus.w_addr]), MAX_DW'(bus.w_data),
                                     MAX_NB'(bus.w_be), byte_width));
`ifdef RAM_BYPASS_EN
    if (wr_en_s && rd_en_s && (bus.r_addr == bus.w_addr)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_q[bus.r_addr];
    end
`else
    rd_word_s = mem_q[bus.r_addr];
`endif
    if (rd_en_s) begin
      r_data_d = rd_word_s;
    end else begin
      r_data_d = r_data_q;
    end
    r_valid_d = rd_en_s;
  end

  // Storage array: the sweep owns the write port while it runs; no reset on contents.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_q[clr_addr_s] <= CLR_WORD;
    end else if (wr_en_s) begin
      mem_q[bus.w_addr] <= wr_word_s;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  assign bus.busy    = busy_s;
  assign bus.r_data  = r_data_q;
  assign bus.r_valid = r_valid_q;

endmodule

// File: tb/tb_ram_2ports_be_clr.sv
// Self-checking bench for ram_2ports_be_clr: directed scenarios plus random traffic
// compared against a word-array reference model.
module tb_ram_2ports_be_clr;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int BW    = 8;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 2 ** AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ram_2ports_be_clr_if #(.addr_width(AW), .data_width(DW), .byte_width(BW)) bus_if ();

  ram_2ports_be_clr #(
    .addr_width (AW),
    .data_width (DW),
    .byte_width (BW),
    .clr_value  (8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  int            mdl_sweep_left = DEPTH;
  logic [DW-1:0] mdl_r_data     = 16'h0000;
  logic          mdl_r_valid    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] res;
    for (int l = 0; l < NB; l++) begin
      res[l*BW +: BW] = be[l] ? new_w[l*BW +: BW] : old_w[l*BW +: BW];
    end
    return res;
  endfunction

  // Reference behaviour at one rising edge, from the inputs held across it.
  task automatic model_edge();
    logic do_wr;
    if (!rst_n) begin
      mdl_sweep_left = DEPTH;
      mdl_r_data     = 16'h0000;
      mdl_r_valid    = 1'b0;
    end else if (mdl_sweep_left > 0) begin
      mdl_mem[DEPTH - mdl_sweep_left] = 16'h0000;
      mdl_sweep_left--;
      mdl_r_valid = 1'b0;
    end else begin
      do_wr = bus_if.we && !bus_if.clr_req;
      if (bus_if.re) begin
        mdl_r_valid = 1'b1;
        mdl_r_data  = mdl_mem[bus_if.r_addr];
`ifdef RAM_BYPASS_EN
        if (do_wr && (bus_if.r_addr == bus_if.w_addr)) begin
          mdl_r_data = lane_merge(mdl_mem[bus_if.w_addr], bus_if.w_data, bus_if.w_be);
        end
`endif
      end else begin
        mdl_r_valid = 1'b0;
      end
      if (bus_if.clr_req) begin
        mdl_sweep_left = DEPTH;
      end else if (do_wr) begin
        mdl_mem[bus_if.w_addr] = lane_merge(mdl_mem[bus_if.w_addr], bus_if.w_data, bus_if.w_be);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("busy",    32'(bus_if.busy),    32'(mdl_sweep_left > 0));
    check_eq("r_valid", 32'(bus_if.r_valid), 32'(mdl_r_valid));
    check_eq("r_data",  32'(bus_if.r_data),  32'(mdl_r_data));
  endtask

  task automatic set_idle();
    bus_if.we      = 1'b0;
    bus_if.re      = 1'b0;
    bus_if.clr_req = 1'b0;
  endtask

  task automatic drive_random(input int clr_den);
    bus_if.we      = 1'($urandom_range(0, 1));
    bus_if.re      = 1'($urandom_range(0, 1));
    bus_if.w_addr  = 4'($urandom_range(0, DEPTH - 1));
    bus_if.r_addr  = 4'($urandom_range(0, DEPTH - 1));
    bus_if.w_data  = 16'($urandom);
    bus_if.w_be    = 2'($urandom_range(0, 3));
    bus_if.clr_req = (clr_den > 0) ? ($urandom_range(0, clr_den - 1) == 0) : 1'b0;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    bus_if.we     = 1'b1;
    bus_if.w_addr = a;
    bus_if.w_data = d;
    bus_if.w_be   = be;
  endtask

  task automatic read_word(input logic [AW-1:0] a);
    bus_if.re     = 1'b1;
    bus_if.r_addr = a;
  endtask

  // Counts samples with busy high from now until it drops (bounded).
  task automatic count_busy(input string tag, input bit rnd);
    int n;
    n = bus_if.busy ? 1 : 0;
    for (int k = 0; k < 40 && bus_if.busy; k++) begin
      if (rnd) drive_random(3);
      else     set_idle();
      step();
      if (bus_if.busy) n++;
    end
    set_idle();
    check_eq(tag, 32'(n), 32'd16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    bus_if.w_addr = 4'h0;
    bus_if.r_addr = 4'h0;
    bus_if.w_data = 16'h0000;
    bus_if.w_be   = 2'b00;
    repeat (3) step();
    check_eq("rst_busy",  32'(bus_if.busy),    32'd1);
    check_eq("rst_valid", 32'(bus_if.r_valid), 32'd0);
    check_eq("rst_data",  32'(bus_if.r_data),  32'h0);

    // 1: power-up sweep, then every address reads zero back-to-back
    rst_n = 1'b1;
    count_busy("t1_busy_len", 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      read_word(4'(a));
      step();
      check_eq("t1_rd_data",  32'(bus_if.r_data),  32'h0);
      check_eq("t1_rd_valid", 32'(bus_if.r_valid), 32'd1);
    end
    set_idle();
    step();

    // 2: byte-lane partial overwrite
    write_word(4'd3, 16'hABCD, 2'b11);
    step();
    write_word(4'd3, 16'h1234, 2'b01);
    step();
    set_idle();
    read_word(4'd3);
    step();
    check_eq("t2_merge", 32'(bus_if.r_data), 32'hAB34);
    set_idle();

    // 3: same-address collision
    write_word(4'd5, 16'h1111, 2'b11);
    step();
    write_word(4'd5, 16'h5A5A, 2'b10);
    read_word(4'd5);
    step();
`ifdef RAM_BYPASS_EN
    check_eq("t3_collide", 32'(bus_if.r_data), 32'h5A11);
`else
    check_eq("t3_collide", 32'(bus_if.r_data), 32'h1111);
`endif
    set_idle();
    read_word(4'd5);
    step();
    check_eq("t3_after", 32'(bus_if.r_data), 32'h5A11);
    set_idle();

    // 6: back-to-back reads at the address extremes, then hold
    write_word(4'd15, 16'hBEEF, 2'b11);
    step();
    write_word(4'd0, 16'hC0DE, 2'b11);
    step();
    set_idle();
    read_word(4'd15);
    step();
    check_eq("t6_rd15", 32'(bus_if.r_data), 32'hBEEF);
    check_eq("t6_v15",  32'(bus_if.r_valid), 32'd1);
    read_word(4'd0);
    step();
    check_eq("t6_rd0", 32'(bus_if.r_data), 32'hC0DE);
    check_eq("t6_v0",  32'(bus_if.r_valid), 32'd1);
    set_idle();
    step();
    check_eq("t6_hold",    32'(bus_if.r_data),  32'hC0DE);
    check_eq("t6_novalid", 32'(bus_if.r_valid), 32'd0);

    // 4: fill, then clear request racing a write and a read
    for (int a = 0; a < DEPTH; a++) begin
      write_word(4'(a), 16'hFFFF, 2'b11);
      step();
    end
    write_word(4'd0, 16'h7777, 2'b11);
    read_word(4'd0);
    bus_if.clr_req = 1'b1;
    step();
    check_eq("t4_preclr_rd", 32'(bus_if.r_data),  32'hFFFF);
    check_eq("t4_preclr_v",  32'(bus_if.r_valid), 32'd1);
    count_busy("t4_busy_len", 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      read_word(4'(a));
      step();
      check_eq("t4_cleared", 32'(bus_if.r_data), 32'h0);
    end
    set_idle();

    // 5: reset in the middle of a sweep restarts it
    bus_if.clr_req = 1'b1;
    step();
    set_idle();
    repeat (7) step();
    read_word(4'd2);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy",  32'(bus_if.busy),    32'd1);
    check_eq("t5_rst_valid", 32'(bus_if.r_valid), 32'd0);
    step();
    rst_n = 1'b1;
    set_idle();
    count_busy("t5_busy_len", 1'b0);

    // Random traffic with occasional clear requests
    for (int i = 0; i < 400; i++) begin
      drive_random(50);
      step();
    end
    set_idle();
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
